// File: rtl/sram_wb_responder.sv
// Wishbone classic slave for the four packet-buffer SRAM banks: decodes the bank,
// drives the shared SRAM port from registers and returns a registered ack with read data.
module sram_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SRAM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [3:0]             sram_csb,
  output logic                   sram_web,
  output logic [3:0]             sram_wmask,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_din,
  input  logic [31:0]            sram_dout0,
  input  logic [31:0]            sram_dout1,
  input  logic [31:0]            sram_dout2,
  input  logic [31:0]            sram_dout3
);

  localparam int TAG_LSB = SRAM_ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ACK} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             csb_q, csb_d;
  logic                   web_q, web_d;
  logic [3:0]             wmask_q, wmask_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            din_q, din_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;
  logic [1:0]             bank_q, bank_d;
  logic                   we_q, we_d;

  logic        req;
  logic        hit;
  logic [1:0]  adr_bank;
  logic [31:0] dout_sel;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign hit      = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign adr_bank = wbs_adr_i[SRAM_ADDR_W+1:SRAM_ADDR_W];

  always_comb begin
    case (bank_q)
      2'd0:    dout_sel = sram_dout0;
      2'd1:    dout_sel = sram_dout1;
      2'd2:    dout_sel = sram_dout2;
      default: dout_sel = sram_dout3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    bank_d  = bank_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            csb_d   = ~(4'b0001 << adr_bank);
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
            addr_d  = wbs_adr_i[SRAM_ADDR_W-1:0];
            din_d   = wbs_dat_i;
            bank_d  = adr_bank;
            we_d    = wbs_we_i;
            state_d = ACCESS;
          end else begin
            // Out-of-window: acknowledge with zero data, writes are dropped.
            dat_d   = 32'h0;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACCESS: begin
        // The SRAM samples the controls at the edge closing this cycle, even on abort.
        csb_d   = 4'hF;
        web_d   = 1'b1;
        wmask_d = 4'h0;
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          dat_d   = dout_sel;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      csb_q   <= 4'hF;
      web_q   <= 1'b1;
      wmask_q <= 4'h0;
      addr_q  <= '0;
      din_q   <= 32'h0;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      bank_q  <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_wb_responder.sv
// Bench for sram_wb_responder: four behavioural SRAM banks plus a word-level
// reference memory; directed cases from the plan followed by random traffic.
module tb_sram_wb_responder;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [3:0]  csb;
  logic        web;
  logic [3:0]  wmask;
  logic [9:0]  saddr;
  logic [31:0] sdin;
  logic [31:0] dout [4];

  logic [31:0] sram_mem [4][1024];
  logic [31:0] ref_mem  [4][1024];
  logic [31:0] exp_dat;
  int          n_checks = 0;
  int          n_errors = 0;

  sram_wb_responder dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
    .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .sram_csb(csb), .sram_web(web), .sram_wmask(wmask), .sram_addr(saddr), .sram_din(sdin),
    .sram_dout0(dout[0]), .sram_dout1(dout[1]), .sram_dout2(dout[2]), .sram_dout3(dout[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port banks; idle banks drive garbage so a wrong mux shows up.
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (!csb[n]) begin
        if (!web) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) sram_mem[n][saddr][8*b +: 8] <= sdin[8*b +: 8];
        end else begin
          dout[n] <= sram_mem[n][saddr];
        end
      end else begin
        dout[n] <= $urandom;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request in the current IDLE cycle and follows it to its ack.
  task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic keep);
    logic        hit;
    int          bank, exp_lat, ncyc;
    logic [31:0] exp_rd;
    hit     = (adr[31:12] == 20'h30000);
    bank    = int'(adr[11:10]);
    exp_lat = !hit ? 1 : (we ? 2 : 3);
    exp_rd  = hit ? ref_mem[bank][adr[9:0]] : 32'h0;
    cyc = 1'b1; stb = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
    if (hit && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[bank][adr[9:0]][8*b +: 8] = dat[8*b +: 8];
    ncyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      ncyc++;
      if (hit && ncyc == 1) begin
        check("csb_t1", {28'h0, csb}, {28'h0, ~(4'b0001 << bank)});
        check("web_t1", {31'h0, web}, {31'h0, ~we});
        check("wmask_t1", {28'h0, wmask}, we ? {28'h0, sel} : 32'h0);
        check("addr_t1", {22'h0, saddr}, {22'h0, adr[9:0]});
        check("din_t1", sdin, dat);
      end else if (hit && ncyc == 2) begin
        check("csb_rel", {28'h0, csb}, 32'hF);
      end
      if (!hit) check("csb_miss", {28'h0, csb}, 32'hF);
      if (ack) break;
    end
    check("latency", ncyc, exp_lat);
    if (!hit) exp_dat = 32'h0;
    else if (!we) exp_dat = exp_rd;
    check("dat_ack", dat_o, exp_dat);
    if (!keep) begin cyc = 1'b0; stb = 1'b0; end
    @(posedge clk); #1;
    check("ack_pulse", {31'h0, ack}, 32'h0);
    check("dat_hold", dat_o, exp_dat);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 1024; i++) begin
        sram_mem[n][i] = 32'h0;
        ref_mem[n][i]  = 32'h0;
      end
    exp_dat = 32'h0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we_i = 1'b0; sel_i = 4'h0; adr_i = 32'h0; dat_i = 32'h0;

    // Reset held with random bus activity.
    for (int i = 0; i < 5; i++) begin
      cyc = 1'($urandom); stb = 1'($urandom); we_i = 1'($urandom);
      sel_i = 4'($urandom); adr_i = 32'h3000_0000 | 32'($urandom_range(0, 4095)); dat_i = $urandom;
      @(posedge clk); #1;
      check("rst_csb", {28'h0, csb}, 32'hF);
      check("rst_web", {31'h0, web}, 32'h1);
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_dat", dat_o, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_wmask", {28'h0, wmask}, 32'h0);

    // Directed: bank 2 write/read, byte mask, miss.
    access(1'b1, 32'h3000_0804, 4'hF, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h3000_0804, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h3000_0C00, 4'b0101, 32'h1122_3344, 1'b0);
    access(1'b0, 32'h3000_0C00, 4'hF, 32'h0, 1'b0);
    access(1'b0, 32'h3000_1000, 4'hF, 32'h0, 1'b0);

    // stb without cyc is ignored.
    stb = 1'b1; adr_i = 32'h3000_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stb_only_csb", {28'h0, csb}, 32'hF);
      check("stb_only_ack", {31'h0, ack}, 32'h0);
    end
    stb = 1'b0;

    // Abort a bank-0 read in RDATA, then a bank-1 write must proceed normally.
    access(1'b1, 32'h3000_0010, 4'hF, 32'hA5A5_0010, 1'b0);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0010;
    @(posedge clk); #1;
    check("abort_csb_t1", {28'h0, csb}, 32'hE);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_ack", {31'h0, ack}, 32'h0);
      check("abort_csb", {28'h0, csb}, 32'hF);
    end
    check("abort_dat", dat_o, exp_dat);
    access(1'b1, 32'h3000_0408, 4'hF, 32'h0BAD_F00D, 1'b0);
    access(1'b0, 32'h3000_0408, 4'h0, 32'h0, 1'b0);

    // Write aborted in ACCESS still commits.
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = 32'h3000_0C20; dat_i = 32'hCAFE_0C20;
    ref_mem[3][10'h020] = 32'hCAFE_0C20;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("wabort_ack", {31'h0, ack}, 32'h0);
    check("wabort_csb", {28'h0, csb}, 32'hF);
    access(1'b0, 32'h3000_0C20, 4'h0, 32'h0, 1'b0);

    // Back-to-back reads across all banks with stb held.
    for (int n = 0; n < 4; n++)
      access(1'b1, 32'h3000_0005 | (32'(n) << 10), 4'hF, 32'h1000_0000 * (n + 1) + 32'h55, 1'b0);
    for (int n = 0; n < 4; n++)
      access(1'b0, 32'h3000_0005 | (32'(n) << 10), 4'h0, 32'h0, (n != 3));

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom);
      d = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[31:12] == 20'h30000) a[20] = 1'b1;
      end else begin
        a = {20'h30000, 2'($urandom), 6'h0, 4'($urandom)};
      end
      access(w, a, 4'($urandom), d, 1'($urandom));
    end
    cyc = 1'b0; stb = 1'b0;

    // Reset in the middle of a read.
    access(1'b0, 32'h3000_0C00, 4'hF, 32'h0, 1'b0);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0C01;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_dat = 32'h0;
    check("midrst_csb", {28'h0, csb}, 32'hF);
    check("midrst_ack", {31'h0, ack}, 32'h0);
    check("midrst_dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_noack", {31'h0, ack}, 32'h0);
    access(1'b0, 32'h3000_0804, 4'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
